// File: rtl/sr_drive_pkg.sv
// Shared definitions for the SR bank driver: FSM state encoding and width helpers.
package sr_drive_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Bits needed to hold a try count of 1..max_retry+1.
    function automatic int tries_w(input int max_retry);
        return (max_retry + 2 > 2) ? $clog2(max_retry + 2) : 1;
    endfunction

endpackage

// File: rtl/sr_excite.sv
// SR flip-flop excitation: per bit, set when q must rise, reset when q must fall, else hold.
// s and r are never both high for the same bit.
module sr_excite #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    assign s = ~q & t;
    assign r = q & ~t;

endmodule

// File: rtl/sr_bank_driver.sv
// Drives a bank of SR flip-flops towards a requested word, verifies the read-back,
// retries on mismatch and reports the outcome on a valid/ready response channel.
module sr_bank_driver
    import sr_drive_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int MAX_RETRY     = 3,
    parameter int SETTLE_CYCLES = 0,
    parameter int ERR_W         = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    input  logic [WIDTH-1:0]                req_data,
    output logic                            req_ready,
    output logic [WIDTH-1:0]                s_out,
    output logic [WIDTH-1:0]                r_out,
    input  logic [WIDTH-1:0]                q_in,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_ok,
    output logic [tries_w(MAX_RETRY)-1:0]   resp_tries,
    output logic [ERR_W-1:0]                err_count
);

    localparam int TW = tries_w(MAX_RETRY);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             resp_ok_q, resp_ok_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
    logic [WIDTH-1:0] exc_t, exc_s, exc_r;

    // Excitation target: the incoming word on accept, otherwise the latched target for retries.
    assign exc_t = (state_q == ST_IDLE) ? req_data : target_q;

    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .q (q_in),
        .t (exc_t),
        .s (exc_s),
        .r (exc_r)
    );

    // Next-state logic for the drive/check/retry sequence and the error counter.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        tries_d   = tries_q;
        settle_d  = settle_q;
        resp_ok_d = resp_ok_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    target_d = req_data;
                    tries_d  = '0;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                tries_d  = tries_q + 1'b1;
                settle_d = '0;
                state_d  = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (q_in == target_q) begin
                    resp_ok_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (tries_q <= TW'(MAX_RETRY)) begin
                    state_d = ST_DRIVE;
                end else begin
                    resp_ok_d = 1'b0;
                    state_d   = ST_RESP;
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drive lines are loaded only on entry to DRIVE, so they are high for exactly that one cycle.
    always_comb begin
        s_d = '0;
        r_d = '0;
        if (state_d == ST_DRIVE) begin
            s_d = exc_s;
            r_d = exc_r;
        end
    end

    // Control and output registers; reset clears everything visible to the bank and the requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tries_q   <= '0;
            settle_q  <= '0;
            resp_ok_q <= 1'b0;
            err_q     <= '0;
            s_q       <= '0;
            r_q       <= '0;
        end else begin
            state_q   <= state_d;
            tries_q   <= tries_d;
            settle_q  <= settle_d;
            resp_ok_q <= resp_ok_d;
            err_q     <= err_d;
            s_q       <= s_d;
            r_q       <= r_d;
        end
    end

    // Target word is pure data; it is always rewritten before use.
    always_ff @(posedge clk) begin
        target_q <= target_d;
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_ok    = resp_ok_q;
    assign resp_tries = tries_q;
    assign err_count  = err_q;
    assign s_out      = s_q;
    assign r_out      = r_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: table of directed requests against a modelled SR bank,
// hand sequences for reset and back-pressure, then random requests vs a reference model.
module tb_sr_bank_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ready;
    logic [7:0] s_out, r_out, q_in;
    logic       resp_valid, resp_ready, resp_ok;
    logic [2:0] resp_tries;
    logic [7:0] err_count;

    int compared   = 0;
    int mismatched = 0;
    int overlap_seen = 0;

    // Bank model: 8 posedge SR flip-flops, optional stuck-at-0 bits, preload port.
    logic [7:0] bank_q = 8'h00;
    logic [7:0] stuck0 = 8'h00;
    logic       bank_load = 1'b0;
    logic [7:0] bank_load_val = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_load) bank_q <= bank_load_val;
        else           bank_q <= (bank_q & ~r_out) | s_out;
    end
    assign q_in = bank_q & ~stuck0;

    always @(negedge clk) begin
        if ((s_out & r_out) != 8'h00) overlap_seen++;
    end

    sr_bank_driver #(.WIDTH(8), .MAX_RETRY(3), .SETTLE_CYCLES(0), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .s_out(s_out), .r_out(r_out), .q_in(q_in), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_ok(resp_ok), .resp_tries(resp_tries), .err_count(err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic load_bank(input logic [7:0] v);
        @(negedge clk);
        bank_load = 1'b1;
        bank_load_val = v;
        @(negedge clk);
        bank_load = 1'b0;
    endtask

    // One full request: returns first-drive s/r, response fields, latency and pulse count.
    task automatic do_req(input logic [7:0] t, output logic ok, output logic [2:0] tries,
                          output logic [7:0] s1, output logic [7:0] r1,
                          output int lat, output int pulses);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_data  = t;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        s1 = s_out;
        r1 = r_out;
        lat = 1;
        pulses = ((s_out | r_out) != 8'h00) ? 1 : 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if ((s_out | r_out) != 8'h00) pulses++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
        ok = resp_ok;
        tries = resp_tries;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] q_init;
        logic [7:0] target;
        logic [7:0] stuck;
        logic [7:0] exp_s;
        logic [7:0] exp_r;
        logic       exp_ok;
        logic [2:0] exp_tries;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       ok;
        logic [2:0] tries;
        logic [7:0] s1, r1, mq, t;
        int         lat, pulses, exp_err, bad;

        vecs[0] = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b1, 3'd1, 1};
        vecs[1] = '{8'hF0, 8'h3C, 8'h00, 8'h0C, 8'hC0, 1'b1, 3'd1, 1};
        vecs[2] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 3'd4, 4};
        vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 3'd1, 1};
        vecs[4] = '{8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1, 3'd1, 0};
        vecs[5] = '{8'h0F, 8'hF0, 8'h80, 8'hF0, 8'h0F, 1'b0, 3'd4, 4};

        rst = 1'b1; req_valid = 1'b0; req_data = 8'h00; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_ok", 32'(resp_ok), 0);
        chk("rst_resp_tries", 32'(resp_tries), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_sr", {16'h0, s_out, r_out}, 0);
        rst = 1'b0;

        // Directed table.
        exp_err = 0;
        foreach (vecs[i]) begin
            stuck0 = vecs[i].stuck;
            load_bank(vecs[i].q_init);
            do_req(vecs[i].target, ok, tries, s1, r1, lat, pulses);
            chk($sformatf("v%0d_s", i), 32'(s1), 32'(vecs[i].exp_s));
            chk($sformatf("v%0d_r", i), 32'(r1), 32'(vecs[i].exp_r));
            chk($sformatf("v%0d_ok", i), 32'(ok), 32'(vecs[i].exp_ok));
            chk($sformatf("v%0d_tries", i), 32'(tries), 32'(vecs[i].exp_tries));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(2 * vecs[i].exp_tries + 1));
            chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
            chk($sformatf("v%0d_q", i), 32'(q_in), 32'(vecs[i].target & ~vecs[i].stuck));
            if (!vecs[i].exp_ok) exp_err++;
            chk($sformatf("v%0d_err", i), 32'(err_count), 32'(exp_err));
        end
        stuck0 = 8'h00;

        // Reset while the drive pulse is on the bank.
        load_bank(8'h00);
        req_valid = 1'b1;
        req_data  = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_drive_s", 32'(s_out), 32'h3C);
        rst = 1'b1;
        #1;
        chk("rst_async_s", 32'(s_out), 0);
        chk("rst_async_r", 32'(r_out), 0);
        chk("rst_async_ready", 32'(req_ready), 1);
        chk("rst_async_err", 32'(err_count), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || !req_ready) bad++;
        end
        chk("rst_no_resp", 32'(bad), 0);
        chk("rst_bank_untouched", 32'(q_in), 0);

        // Response back-pressure: held stable, new request not accepted meanwhile.
        load_bank(8'h00);
        req_valid = 1'b1;
        req_data  = 8'h81;
        @(posedge clk);
        @(negedge clk);
        req_data = 8'h7E;
        bad = 0;
        while (!resp_valid && bad < 20) begin
            @(negedge clk);
            bad++;
        end
        chk("bp_resp_valid", 32'(resp_valid), 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!resp_valid || !resp_ok || resp_tries != 3'd1 || req_ready) bad++;
        end
        chk("bp_stable", 32'(bad), 0);
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_resp_dropped", 32'(resp_valid), 0);
        chk("bp_ready_back", 32'(req_ready), 1);
        chk("bp_q", 32'(q_in), 32'h81);

        // Random targets on a healthy bank versus the reference model.
        mq = 8'h81;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            t = 8'($urandom);
            do_req(t, ok, tries, s1, r1, lat, pulses);
            if (s1 !== (~mq & t) || r1 !== (mq & ~t) || ok !== 1'b1 || tries !== 3'd1
                || lat != 3 || q_in !== t) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_req%0d actual s=%h r=%h ok=%b tries=%0d lat=%0d q=%h required s=%h r=%h ok=1 tries=1 lat=3 q=%h",
                             n, s1, r1, ok, tries, lat, q_in, ~mq & t, mq & ~t, t);
            end
            mq = t;
        end
        chk("rand_requests", 32'(bad), 0);
        chk("rand_err_count", 32'(err_count), 0);
        chk("sr_never_both", 32'(overlap_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
